// File: rtl/fb_write_ctrl_if.sv
// Bundles the renderer draw handshake with the framebuffer write port.
// The controller is the master: it consumes draw pixels and drives the write port.
interface fb_write_ctrl_if #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int DATAW  = 1
);
    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(HEIGHT);
    localparam int ADDRW = $clog2(WIDTH * HEIGHT);

    logic             draw_valid;
    logic             draw_ready;
    logic [XW-1:0]    draw_x;
    logic [YW-1:0]    draw_y;
    logic [DATAW-1:0] draw_color;

    logic             fb_we;
    logic [ADDRW-1:0] fb_addr;
    logic [DATAW-1:0] fb_data;

    modport master (
        input  draw_valid, draw_x, draw_y, draw_color,
        output draw_ready,
        output fb_we, fb_addr, fb_data
    );

    modport slave (
        output draw_valid, draw_x, draw_y, draw_color,
        input  draw_ready,
        input  fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/fb_write_ctrl.sv
// Framebuffer write-port controller: clipped coordinate draws plus a full-screen clear sweep.
// Optional clip statistics counter enabled by defining FB_CLIP_STATS_EN.
module fb_write_ctrl #(
    parameter int  WIDTH  = 320,
    parameter int  HEIGHT = 240,
    parameter int  DATAW  = 1,
    localparam int ADDRW  = $clog2(WIDTH * HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    fb_write_ctrl_if.master       bus,
    input  logic                  clear_start,
    input  logic [DATAW-1:0]      clear_value,
`ifdef FB_CLIP_STATS_EN
    output logic [15:0]           clip_count,
`endif
    output logic                  busy,
    output logic                  clear_done
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    localparam logic [XW:0]       X_LIMIT   = WIDTH[XW:0];
    localparam logic [YW:0]       Y_LIMIT   = HEIGHT[YW:0];
    localparam logic [ADDRW-1:0]  LINE      = ADDRW'(WIDTH);
    localparam logic [ADDRW-1:0]  LAST_ADDR = ADDRW'(WIDTH * HEIGHT - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state;
    logic             fire;
    logic             in_range;
    logic [ADDRW-1:0] pix_addr;

    assign bus.draw_ready = (state == IDLE) && !clear_start;
    assign fire           = bus.draw_valid && bus.draw_ready;
    assign in_range       = ({1'b0, bus.draw_x} < X_LIMIT) && ({1'b0, bus.draw_y} < Y_LIMIT);
    assign pix_addr       = ADDRW'(bus.draw_y) * LINE + ADDRW'(bus.draw_x);

    // During the sweep fb_addr doubles as the clear counter and fb_data holds the fill colour.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            clear_done  <= 1'b0;
            bus.fb_we   <= 1'b0;
            bus.fb_addr <= '0;
            bus.fb_data <= '0;
        end else begin
            bus.fb_we  <= 1'b0;
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state       <= CLEAR;
                        busy        <= 1'b1;
                        bus.fb_we   <= 1'b1;
                        bus.fb_addr <= '0;
                        bus.fb_data <= clear_value;
                    end else if (fire && in_range) begin
                        bus.fb_we   <= 1'b1;
                        bus.fb_addr <= pix_addr;
                        bus.fb_data <= bus.draw_color;
                    end
                end
                CLEAR: begin
                    if (bus.fb_addr == LAST_ADDR) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        bus.fb_we   <= 1'b1;
                        bus.fb_addr <= bus.fb_addr + ADDRW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FB_CLIP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && clear_start)) begin
            clip_count <= '0;
        end else if (fire && !in_range && clip_count != 16'hFFFF) begin
            clip_count <= clip_count + 16'd1;
        end
    end
`else
    // Clip statistics are not built in this configuration.
`endif
endmodule

// File: doc/fb_write_ctrl.md
Name: fb_write_ctrl

Overview:
- Write-port controller that owns the single write port of the pixel framebuffer (the on-chip RAM with one synchronous write port and one registered read port).
- Shares that port between two requesters:
  - a coordinate-based draw stream (x, y, colour) from the renderer;
  - an internal full-screen clear engine.
- Converts coordinates to linear addresses, drops off-screen pixels, and sequences the clear sweep.
- Sits between the renderer and the framebuffer write interface. The read/scan side is untouched.

Parameters:
- WIDTH, 320, pixels per line.
- HEIGHT, 240, lines per frame.
- DATAW, 1, bits per pixel.
- ADDRW, $clog2(WIDTH*HEIGHT), framebuffer address width (derived; do not override).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear_start  in  1  one-cycle request to clear the whole buffer.
- clear_value  in  DATAW  fill colour, sampled on the accepted clear_start cycle.
- draw_valid  in  1  draw pixel request.
- draw_ready  out  1  controller can accept a pixel this cycle.
- draw_x  in  $clog2(WIDTH)  pixel column.
- draw_y  in  $clog2(HEIGHT)  pixel row.
- draw_color  in  DATAW  pixel colour.
- busy  out  1  high while the clear sweep is in progress.
- clear_done  out  1  one-cycle pulse when the clear sweep completes.
- fb_we  out  1  framebuffer write enable.
- fb_addr  out  ADDRW  framebuffer write address.
- fb_data  out  DATAW  framebuffer write data.

Behaviour:
- States: IDLE, CLEAR.
- Reset (rst=1 at a clock edge):
  - state goes to IDLE.
  - fb_we, fb_addr, fb_data, busy, clear_done are 0.
  - Clear counter and the clip counter (if built) are 0.
  - A reset during CLEAR aborts the sweep with no clear_done pulse. Already-written locations keep their values.
- draw_ready = (state==IDLE) && !clear_start. This is combinational, and clear_start has priority over draw.
- Draw path:
  - Handshake fires when draw_valid && draw_ready.
  - If draw_x < WIDTH and draw_y < HEIGHT, the next cycle drives fb_we=1, fb_addr = draw_y*WIDTH + draw_x, fb_data = draw_color.
  - Latency is 1 cycle, registered outputs, one pixel per cycle sustained.
  - An out-of-range pixel is accepted and consumed, and fb_we stays 0 the next cycle.
  - The multiply is constant-by-variable, computed at ADDRW width, with no truncation for in-range inputs.
- Clear path:
  - clear_start in IDLE latches clear_value, and the state moves to CLEAR next cycle.
  - In CLEAR, each cycle drives fb_we=1, fb_addr=cnt, fb_data=latched value, with cnt running 0 to WIDTH*HEIGHT-1. The sweep takes exactly WIDTH*HEIGHT cycles.
  - busy=1 for every CLEAR cycle.
  - In the cycle after the write to WIDTH*HEIGHT-1: state is IDLE, busy=0, clear_done=1 for 1 cycle, fb_we=0.
  - draw_ready rises in that same cycle.
  - clear_start during CLEAR is ignored: no restart, no second done pulse.
- Simultaneous clear_start and draw_valid in IDLE: the clear wins, the draw is not accepted (ready=0), and the renderer must hold valid.
- When neither path writes, fb_we=0. fb_addr and fb_data hold their last values.
- The write port is never driven by both paths in the same cycle. This holds by construction.

Optional Feature:
- Macro: FB_CLIP_STATS_EN.
- With the macro defined:
  - adds output port clip_count, 16 bits.
  - A saturating count of accepted out-of-range draw pixels: it increments 1 cycle after each such handshake and holds at 16'hFFFF.
  - It resets to 0 on rst and on each accepted clear_start.
- Without the macro: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Small frame: WIDTH=8, HEIGHT=4, DATAW=4, reset released.
  - Draw (x=3,y=2,c=4'hA) with valid for 1 cycle -> next cycle fb_we=1, fb_addr=19, fb_data=4'hA. The cycle after that, fb_we=0.
- Out-of-range draw: draw (x=7,y=3) then (x=8 encoded via x=3'b... for WIDTH=10 use x=12,y=0) -> first produces a write to address 31. Second is accepted (ready=1) and gives fb_we=0. With FB_CLIP_STATS_EN, clip_count=1.
- Normal clear: clear_start with clear_value=4'h5 -> 32 consecutive cycles with fb_we=1, addresses 0..31, data 5, busy=1. Then clear_done pulses once, busy=0, draw_ready=1.
- Contention and mid-sweep requests:
  - clear_start and draw_valid in the same cycle -> draw_ready=0, the sweep starts, and the held draw is written on the first cycle after clear_done.
  - A second clear_start at sweep cycle 10 -> ignored, still exactly 32 writes total.
- Reset at sweep cycle 12 -> next cycle fb_we=0, busy=0, clear_done never pulses, draw_ready=1.
- Back-to-back draws for 20 cycles with valid held -> 20 writes on consecutive cycles, each address equal to y*8+x of the pixel accepted the previous cycle.
